// File: rtl/op_issue_queue.sv
// op_issue_queue: in-order operation FIFO feeding the encoder/ALU datapath.
// Define ONEHOT_CHECK_EN to reject (and count) pushes whose function code is not one-hot.
module op_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_func,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_func,
  output logic [3:0]               out_a,
  output logic [3:0]               out_b,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop, ok, store;
  assign in_ready  = level_q < FULL;
  assign out_valid = level_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
`ifdef ONEHOT_CHECK_EN
  assign ok = (in_func != 8'd0) && ((in_func & (in_func - 8'd1)) == 8'd0);
`else
  assign ok = 1'b1;
`endif
  assign store = push && ok;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign {out_func, out_a, out_b} = out_valid ? mem_q[rptr_q] : 16'd0;
  assign level    = level_q;
  assign drop_cnt = drop_q;
  always_comb begin
    mem_d = mem_q;
    if (store) mem_d[wptr_q] = {in_func, in_a, in_b};
    wptr_d  = wptr_q + PW'(store);
    rptr_d  = rptr_q + PW'(pop);
    level_d = level_q + (PW+1)'(store) - (PW+1)'(pop);
    drop_d  = drop_q + 8'(push && !ok && drop_q != 8'hff);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_op_issue_queue.sv
// tb_op_issue_queue: directed self-checking bench for op_issue_queue (DEPTH=4).
module tb_op_issue_queue;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] in_func = '0, out_func, drop_cnt;
  logic [3:0] in_a = '0, in_b = '0, out_a, out_b;
  logic [2:0] level;
  int errors = 0, checks = 0;
  logic [15:0] exp_q[$];

  op_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_func(out_func), .out_a(out_a), .out_b(out_b),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] f, input logic [3:0] a, input logic [3:0] b);
    in_valid = v; in_func = f; in_a = a; in_b = b;
  endtask

  initial begin
    #2;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_head", {out_func, out_a, out_b}, 0);
    chk("rst_drop", drop_cnt, 0);
    #10 rst_n = 1'b1;
    // first push right after release, datapath stalled
    drive(1, 8'h80, 4'h5, 4'hE);
    step();
    chk("p1_valid", out_valid, 1);
    chk("p1_head", {out_func, out_a, out_b}, 16'h805E);
    chk("p1_level", level, 1);
    drive(1, 8'h40, 4'h1, 4'h1); step();
    drive(1, 8'h20, 4'h2, 4'h2); step();
    drive(1, 8'h10, 4'h3, 4'h3); step();
    chk("full_level", level, 4);
    chk("full_ready", in_ready, 0);
    drive(1, 8'h08, 4'h4, 4'h4); step();
    chk("full_refuse_level", level, 4);
    chk("full_hold_head", {out_func, out_a, out_b}, 16'h805E);
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    step(); chk("drain1", {out_func, out_a, out_b, 1'b0, level}, {16'h4011, 4'd3});
    step(); chk("drain2", {out_func, out_a, out_b, 1'b0, level}, {16'h2022, 4'd2});
    step(); chk("drain3", {out_func, out_a, out_b, 1'b0, level}, {16'h1033, 4'd1});
    step(); chk("drain_empty", {out_valid, out_func, out_a, out_b, level}, 0);
    // push+pop at level 2 across pointer wrap
    out_ready = 1'b0;
    drive(1, 8'h01, 4'hA, 4'h5); step();
    drive(1, 8'h02, 4'hB, 4'h4); step();
    exp_q = '{16'h01A5, 16'h02B4};
    chk("pp_level_pre", level, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1, 8'(1 << k), 4'(k), 4'(~k));
      exp_q.push_back({8'(1 << k), 4'(k), 4'(~k)});
      void'(exp_q.pop_front());
      step();
      chk("pp_level", level, 2);
      chk("pp_head", {out_func, out_a, out_b}, exp_q[0]);
    end
    drive(0, 0, 0, 0);
    step(); chk("pp_tail", {out_func, out_a, out_b}, 16'h8078);
    step(); chk("pp_empty", level, 0);
    // one-hot screening
    out_ready = 1'b0;
    drive(1, 8'h00, 4'h1, 4'h2); step();
    drive(1, 8'hC0, 4'h3, 4'h4); step();
    drive(1, 8'h01, 4'h5, 4'h6); step();
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
`ifdef ONEHOT_CHECK_EN
    chk("oh_drop", drop_cnt, 2);
    chk("oh_level", level, 1);
    chk("oh_head", {out_func, out_a, out_b}, 16'h0156);
    step(); chk("oh_empty", level, 0);
    out_ready = 1'b0;
    drive(1, 8'hFF, 4'h0, 4'h0);
    for (int k = 0; k < 260; k++) step();
    drive(0, 0, 0, 0);
    chk("oh_sat", drop_cnt, 255);
    chk("oh_sat_level", level, 0);
`else
    chk("nc_drop", drop_cnt, 0);
    chk("nc_level", level, 3);
    chk("nc_head0", {out_func, out_a, out_b}, 16'h0012);
    step(); chk("nc_head1", {out_func, out_a, out_b}, 16'hC034);
    step(); chk("nc_head2", {out_func, out_a, out_b}, 16'h0156);
    step(); chk("nc_empty", level, 0);
`endif
    // asynchronous reset mid-operation
    out_ready = 1'b0;
    drive(1, 8'h02, 4'h1, 4'h1); step();
    drive(1, 8'h04, 4'h2, 4'h2); step();
    drive(1, 8'h08, 4'h3, 4'h3); step();
    drive(0, 0, 0, 0);
    chk("ar_level_pre", level, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_level", level, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_head", {out_func, out_a, out_b}, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_drop", drop_cnt, 0);
    #2 rst_n = 1'b1;
    drive(1, 8'h04, 4'h9, 4'h6); step();
    drive(0, 0, 0, 0);
    chk("ar_new_head", {out_func, out_a, out_b}, 16'h0496);
    chk("ar_new_level", level, 1);
    step();
    chk("ar_hold", {out_func, out_a, out_b, 1'b0, level}, {16'h0496, 4'd1});
    out_ready = 1'b1;
    step();
    chk("ar_alone", {out_valid, level}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
